// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: two-entry (main + skid) valid/ready pipeline stage with flush to a bubble payload.
// Optional perf counters are built when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_buf #(
    parameter int          DW         = 32,
    parameter logic [DW-1:0] BUBBLE_VAL = {DW{1'b0}},
    parameter int          CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             up_valid_i,
    output logic             up_ready_o,
    input  logic [DW-1:0]    up_data_i,
    output logic             dn_valid_o,
    input  logic             dn_ready_i,
    output logic [DW-1:0]    dn_data_o,
    input  logic             cnt_clr_i,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] bubble_cnt_o
);
    // Encoding is {main valid, skid valid}; 2'b01 is unreachable.
    typedef enum logic [1:0] {S_EMPTY = 2'b00, S_BUSY = 2'b10, S_FULL = 2'b11} state_t;
    state_t          r_state, w_state;
    logic [DW-1:0]   r_main, r_skid, w_main, w_skid;
    logic            w_up_fire, w_dn_fire;
    assign up_ready_o = (r_state != S_FULL);
    assign dn_valid_o = (r_state != S_EMPTY);
    assign dn_data_o  = r_main;
    assign w_up_fire  = up_valid_i & up_ready_o;
    assign w_dn_fire  = dn_valid_o & dn_ready_i;
    always_comb begin
        w_state = r_state;
        w_main  = r_main;
        w_skid  = r_skid;
        if (flush_i) begin
            w_state = S_EMPTY;
            w_main  = BUBBLE_VAL;
            w_skid  = BUBBLE_VAL;
        end else begin
            case (r_state)
                S_EMPTY: if (w_up_fire) begin
                    w_state = S_BUSY;
                    w_main  = up_data_i;
                end
                S_BUSY: if (w_up_fire && w_dn_fire) begin
                    w_main = up_data_i;
                end else if (w_up_fire) begin
                    w_state = S_FULL;
                    w_skid  = up_data_i;
                end else if (w_dn_fire) begin
                    w_state = S_EMPTY;
                    w_main  = BUBBLE_VAL;
                end
                S_FULL: if (w_dn_fire) begin
                    w_state = S_BUSY;
                    w_main  = r_skid;
                    w_skid  = BUBBLE_VAL;
                end
                default: begin
                    w_state = S_EMPTY;
                    w_main  = BUBBLE_VAL;
                    w_skid  = BUBBLE_VAL;
                end
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_EMPTY;
            r_main  <= BUBBLE_VAL;
            r_skid  <= BUBBLE_VAL;
        end else begin
            r_state <= w_state;
            r_main  <= w_main;
            r_skid  <= w_skid;
        end
    end
`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0] r_stall, r_bubble;
    logic             w_stall, w_bubble;
    assign w_stall      = dn_valid_o & ~dn_ready_i;
    assign w_bubble     = ~dn_valid_o & dn_ready_i;
    assign stall_cnt_o  = r_stall;
    assign bubble_cnt_o = r_bubble;
    // Counters saturate at all-ones; clear wins over increment; flush does not touch them.
    always_ff @(posedge clk) begin
        if (!rst || cnt_clr_i) begin
            r_stall  <= '0;
            r_bubble <= '0;
        end else begin
            r_stall  <= r_stall + {{(CNT_W-1){1'b0}}, w_stall & ~(&r_stall)};
            r_bubble <= r_bubble + {{(CNT_W-1){1'b0}}, w_bubble & ~(&r_bubble)};
        end
    end
`else
    logic w_unused;
    assign w_unused     = cnt_clr_i;
    assign stall_cnt_o  = '0;
    assign bubble_cnt_o = '0;
`endif
endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: directed + random checks of pipe_stage_buf against a queue-based reference model.
module tb_pipe_stage_buf;
    localparam logic [31:0] BUB = 32'hDEAD_0013;
`ifdef PIPE_STAGE_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        rst = 1'b0, flush_i = 1'b0, up_valid_i = 1'b0, dn_ready_i = 1'b0, cnt_clr_i = 1'b0;
    logic [31:0] up_data_i = '0;
    logic        up_ready_o, dn_valid_o, s_up_ready, s_dn_valid;
    logic [31:0] dn_data_o, s_dn_data;
    logic [31:0] stall_cnt_o, bubble_cnt_o;
    logic [1:0]  s_stall, s_bubble;
    int          n_chk = 0, n_err = 0;
    logic [31:0] q[$];
    longint      m_stall = 0, m_bubble = 0, m_s_stall = 0, m_s_bubble = 0;

    always #5 clk = ~clk;

    pipe_stage_buf #(.DW(32), .BUBBLE_VAL(BUB), .CNT_W(32)) u_dut (
        .clk(clk), .rst(rst), .flush_i(flush_i), .up_valid_i(up_valid_i), .up_ready_o(up_ready_o),
        .up_data_i(up_data_i), .dn_valid_o(dn_valid_o), .dn_ready_i(dn_ready_i), .dn_data_o(dn_data_o),
        .cnt_clr_i(cnt_clr_i), .stall_cnt_o(stall_cnt_o), .bubble_cnt_o(bubble_cnt_o)
    );
    pipe_stage_buf #(.DW(32), .BUBBLE_VAL(BUB), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .flush_i(flush_i), .up_valid_i(up_valid_i), .up_ready_o(s_up_ready),
        .up_data_i(up_data_i), .dn_valid_o(s_dn_valid), .dn_ready_i(dn_ready_i), .dn_data_o(s_dn_data),
        .cnt_clr_i(cnt_clr_i), .stall_cnt_o(s_stall), .bubble_cnt_o(s_bubble)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic longint sat_inc(input longint v, input longint max);
        return (v < max) ? v + 1 : v;
    endfunction

    // Checks outputs against the model, applies one cycle of inputs, advances the model.
    task automatic step(input bit rv, input bit fl, input bit uv, input bit dr, input bit cc,
                        input logic [31:0] d);
        int n;
        n = q.size();
        chk("dn_valid", {63'd0, dn_valid_o}, {63'd0, n > 0});
        chk("dn_data", {32'd0, dn_data_o}, {32'd0, (n > 0) ? q[0] : BUB});
        chk("up_ready", {63'd0, up_ready_o}, {63'd0, n < 2});
        chk("stall_cnt", {32'd0, stall_cnt_o}, PERF ? m_stall : 64'd0);
        chk("bubble_cnt", {32'd0, bubble_cnt_o}, PERF ? m_bubble : 64'd0);
        chk("sat_stall", {62'd0, s_stall}, PERF ? m_s_stall : 64'd0);
        chk("sat_bubble", {62'd0, s_bubble}, PERF ? m_s_bubble : 64'd0);
        rst = rv; flush_i = fl; up_valid_i = uv; dn_ready_i = dr; cnt_clr_i = cc; up_data_i = d;
        if (!rv || cc) begin
            m_stall = 0; m_bubble = 0; m_s_stall = 0; m_s_bubble = 0;
        end else if (n > 0 && !dr) begin
            m_stall = sat_inc(m_stall, 64'hFFFF_FFFF);
            m_s_stall = sat_inc(m_s_stall, 3);
        end else if (n == 0 && dr) begin
            m_bubble = sat_inc(m_bubble, 64'hFFFF_FFFF);
            m_s_bubble = sat_inc(m_s_bubble, 3);
        end
        if (!rv || fl) q.delete();
        else begin
            if (n > 0 && dr) void'(q.pop_front());
            if (uv && n < 2) q.push_back(d);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_valid", {63'd0, dn_valid_o}, 64'd0);
        chk("rst_data", {32'd0, dn_data_o}, {32'd0, BUB});
        chk("rst_ready", {63'd0, up_ready_o}, 64'd1);
        chk("rst_stall", {32'd0, stall_cnt_o}, 64'd0);
        chk("rst_bubble", {32'd0, bubble_cnt_o}, 64'd0);
        // streaming 0x1..0x8
        for (int i = 1; i <= 8; i++) begin
            step(1, 0, 1, 1, 0, 32'(i));
            chk("stream_out", {32'd0, dn_data_o}, 64'(i));
        end
        repeat (2) step(1, 0, 0, 1, 0, '0);
        // backpressure: 0xA accepted, 0xB goes to skid, 0xC waits upstream
        step(1, 0, 1, 1, 0, 32'hA);
        step(1, 0, 1, 0, 0, 32'hB);
        step(1, 0, 1, 0, 0, 32'hC);
        chk("bp_ready", {63'd0, up_ready_o}, 64'd0);
        chk("bp_hold", {32'd0, dn_data_o}, 64'hA);
        step(1, 0, 1, 0, 0, 32'hC);
        chk("bp_hold2", {32'd0, dn_data_o}, 64'hA);
        step(1, 0, 1, 1, 0, 32'hC);
        chk("bp_b", {32'd0, dn_data_o}, 64'hB);
        step(1, 0, 1, 1, 0, 32'hC);
        chk("bp_c", {32'd0, dn_data_o}, 64'hC);
        step(1, 0, 0, 1, 0, '0);
        chk("bp_empty", {63'd0, dn_valid_o}, 64'd0);
        // flush while FULL with 0xD presented
        step(1, 0, 1, 0, 0, 32'h11);
        step(1, 0, 1, 0, 0, 32'h12);
        step(1, 1, 1, 0, 0, 32'hD);
        chk("fl_valid", {63'd0, dn_valid_o}, 64'd0);
        chk("fl_data", {32'd0, dn_data_o}, {32'd0, BUB});
        chk("fl_ready", {63'd0, up_ready_o}, 64'd1);
        repeat (2) step(1, 0, 0, 1, 0, '0);
        // perf: 4 stalls then 3 idle-ready cycles
        step(1, 0, 1, 0, 1, 32'h55);
        repeat (4) step(1, 0, 0, 0, 0, '0);
        step(1, 0, 0, 1, 0, '0);
        repeat (3) step(1, 0, 0, 1, 0, '0);
        chk("perf_stall", {32'd0, stall_cnt_o}, PERF ? 64'd4 : 64'd0);
        chk("perf_bubble", {32'd0, bubble_cnt_o}, PERF ? 64'd3 : 64'd0);
        chk("perf_sat", {62'd0, s_stall}, PERF ? 64'd3 : 64'd0);
        step(1, 0, 0, 0, 1, '0);
        chk("perf_clr", {32'd0, stall_cnt_o}, 64'd0);
        step(1, 0, 1, 0, 0, 32'h66);
        repeat (5) step(1, 0, 0, 0, 0, '0);
        chk("sat_5", {62'd0, s_stall}, PERF ? 64'd3 : 64'd0);
        // random traffic
        for (int i = 0; i < 4000; i++)
            step($urandom_range(199) != 0, $urandom_range(19) == 0, $urandom_range(3) != 0,
                 $urandom_range(3) != 0, $urandom_range(99) == 0, $urandom);
        step(1, 0, 0, 1, 0, '0);
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end
endmodule
